sa_fifo_ctrl_256x8: RTL and testbench

//  Valid/ready FIFO controller that owns the write and read ports of the sa_ram_rwst_256x8 two-port RAM.
//  It keeps the write/read pointers and the occupancy count, and issues RAM reads ahead of demand.
//  The RAM's registered-address read output is presented directly as the FIFO head.

---
 rtl/sa_fifo_ctrl_256x8.sv | 54 +++++
 tb/tb_sa_fifo_ctrl_256x8.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_fifo_ctrl_256x8.sv
// sa_fifo_ctrl_256x8: valid/ready FIFO controller owning both ports of an external two-port RAM
module sa_fifo_ctrl_256x8 #(
  parameter int DEPTH = 256,
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW:0]   count,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] unread, count_next;
  logic push, pop;
  assign push = wr_pvld & wr_prdy;
  assign pop = rd_pvld & rd_prdy;
  assign ram_we = push;
  assign ram_wa = wptr;
  assign ram_di = wr_pd;
  assign ram_ra = rptr;
  assign rd_pd = ram_dout;
  assign unread = count - (AW+1)'(rd_pvld);
  assign ram_re = (unread != '0) & (~rd_pvld | rd_prdy) & ~clr;
  assign count_next = clr ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  // pointers wrap naturally at DEPTH; the head register refills whenever its slot is free
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      rd_pvld <= 1'b0;
      wr_prdy <= 1'b0;
    end else begin
      wptr <= clr ? '0 : wptr + AW'(push);
      rptr <= clr ? '0 : rptr + AW'(ram_re);
      count <= count_next;
      rd_pvld <= clr ? 1'b0 : (ram_re | (rd_pvld & ~pop));
      wr_prdy <= clr | (count_next != FULL);
    end
  end
endmodule

// File: tb/tb_sa_fifo_ctrl_256x8.sv
// tb_sa_fifo_ctrl_256x8: directed bench with a queue model of the FIFO and a behavioural RAM
module tb_sa_fifo_ctrl_256x8;
  logic clk = 1'b0;
  logic rstn, clr, wr_pvld, wr_prdy, rd_pvld, rd_prdy, ram_we, ram_re;
  logic [7:0] wr_pd, rd_pd, ram_wa, ram_di, ram_ra, ram_dout;
  logic [8:0] count;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  sa_fifo_ctrl_256x8 dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .count(count),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout)
  );

  // two-port RAM with registered read address
  logic [7:0] mem [256];
  logic [7:0] ra_d = 8'd0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_d <= ram_ra;
  end
  assign ram_dout = mem[ra_d];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // model: queue of held entries with the cycle each was pushed;
  // an entry becomes the valid head two cycles after its push, or one cycle after the previous head leaves
  logic [7:0] q[$];
  int qt[$];
  int cyc = 0;
  bit up = 0;
  logic [7:0] wcnt = 0, fcnt = 0;
  always @(negedge clk) begin
    int mc;
    bit mp, mv, mr, push, pop;
    if (!rstn) begin
      q.delete();
      qt.delete();
      up = 0;
      wcnt = 0;
      fcnt = 0;
    end else begin
      mc = q.size();
      mp = up && mc != 256;
      mv = mc > 0 && qt[0] <= cyc - 2;
      mr = !clr && (mv ? (rd_prdy && mc > 1 && qt[1] <= cyc - 1) : (mc > 0 && qt[0] <= cyc - 1));
      push = wr_pvld && mp;
      pop = mv && rd_prdy;
      chk("count", int'(count), mc);
      chk("count_max", int'(count <= 9'd256), 1);
      chk("wr_prdy", int'(wr_prdy), int'(mp));
      chk("rd_pvld", int'(rd_pvld), int'(mv));
      if (mv) chk("rd_pd", int'(rd_pd), int'(q[0]));
      chk("ram_we", int'(ram_we), int'(push));
      if (push) chk("ram_wa", int'(ram_wa), int'(wcnt));
      if (push) chk("ram_di", int'(ram_di), int'(wr_pd));
      chk("ram_re", int'(ram_re), int'(mr));
      if (mr) chk("ram_ra", int'(ram_ra), int'(fcnt));
      if (clr) begin
        q.delete();
        qt.delete();
        wcnt = 0;
        fcnt = 0;
      end else begin
        if (pop) begin
          void'(q.pop_front());
          void'(qt.pop_front());
        end
        if (push) begin
          q.push_back(wr_pd);
          qt.push_back(cyc);
        end
        wcnt = wcnt + 8'(push);
        fcnt = fcnt + 8'(mr);
      end
      up = 1;
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic drain;
    int n = 0;
    rd_prdy = 1;
    wr_pvld = 0;
    while (count != 0 && n < 3000) begin
      tick;
      n++;
    end
    chk("drained_count", int'(count), 0);
    chk("drained_pvld", int'(rd_pvld), 0);
    rd_prdy = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed, k;
    rstn = 0; clr = 0; wr_pvld = 0; rd_prdy = 0; wr_pd = 0;
    repeat (3) tick;
    samp;
    chk("rst_count", int'(count), 0);
    chk("rst_pvld", int'(rd_pvld), 0);
    chk("rst_prdy", int'(wr_prdy), 0);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_re", int'(ram_re), 0);
    tick;
    rstn = 1;
    samp;
    chk("prdy_after_release", int'(wr_prdy), 0);
    tick;
    // 1: single push latency
    wr_pvld = 1; wr_pd = 8'hA5;
    samp;
    chk("t1_prdy", int'(wr_prdy), 1);
    chk("t1_we", int'(ram_we), 1);
    chk("t1_wa", int'(ram_wa), 0);
    chk("t1_di", int'(ram_di), 8'hA5);
    tick;
    wr_pvld = 0;
    samp;
    chk("t1_re", int'(ram_re), 1);
    chk("t1_ra", int'(ram_ra), 0);
    chk("t1_pvld_early", int'(rd_pvld), 0);
    tick;
    samp;
    chk("t1_pvld", int'(rd_pvld), 1);
    chk("t1_pd", int'(rd_pd), 8'hA5);
    chk("t1_count", int'(count), 1);
    tick;
    drain;
    // 2: fill to full
    wr_pvld = 1;
    for (int i = 0; i < 256; i++) begin
      wr_pd = 8'(i);
      tick;
    end
    wr_pvld = 0;
    samp;
    chk("t2_count", int'(count), 256);
    chk("t2_prdy", int'(wr_prdy), 0);
    chk("t2_head", int'(rd_pd), 0);
    tick;
    // 5: pop and push together at full
    wr_pvld = 1; wr_pd = 8'hEE; rd_prdy = 1;
    samp;
    chk("t5_we", int'(ram_we), 0);
    chk("t5_pop_pd", int'(rd_pd), 0);
    tick;
    wr_pvld = 0;
    samp;
    chk("t5_count", int'(count), 255);
    chk("t5_prdy", int'(wr_prdy), 1);
    chk("t2_drain_1", int'(rd_pd), 1);
    tick;
    for (int i = 2; i < 256; i++) begin
      samp;
      chk("t2_drain_pvld", int'(rd_pvld), 1);
      chk("t2_drain_pd", int'(rd_pd), i);
      tick;
    end
    drain;
    // 3: streaming with random consumer stalls
    pushed = 0;
    k = 0;
    wr_pvld = 1;
    while (pushed < 2000 && k < 20000) begin
      wr_pd = 8'($urandom);
      rd_prdy = 1'($urandom_range(0, 1));
      if (wr_prdy) pushed++;
      tick;
      k++;
    end
    chk("t3_pushed", pushed, 2000);
    drain;
    // 4: stalled head stays put while pushes continue
    wr_pvld = 1; wr_pd = 8'h3C; rd_prdy = 0;
    tick;
    for (int i = 0; i < 12; i++) begin
      wr_pd = 8'(8'h40 + i);
      samp;
      if (i >= 1) begin
        chk("t4_pvld", int'(rd_pvld), 1);
        chk("t4_pd", int'(rd_pd), 8'h3C);
        chk("t4_re", int'(ram_re), 0);
      end
      tick;
    end
    drain;
    // 6: clr with 17 entries
    wr_pvld = 1;
    for (int i = 0; i < 17; i++) begin
      wr_pd = 8'(i);
      tick;
    end
    wr_pd = 8'h99; clr = 1;
    tick;
    clr = 0; wr_pvld = 0;
    samp;
    chk("t6_clr_count", int'(count), 0);
    chk("t6_clr_pvld", int'(rd_pvld), 0);
    chk("t6_clr_prdy", int'(wr_prdy), 1);
    tick;
    wr_pvld = 1; wr_pd = 8'h11;
    tick;
    wr_pvld = 0;
    tick;
    samp;
    chk("t6_clr_next_pvld", int'(rd_pvld), 1);
    chk("t6_clr_next_pd", int'(rd_pd), 8'h11);
    tick;
    drain;
    // 6: reset pulse with 5 entries
    wr_pvld = 1;
    for (int i = 0; i < 5; i++) begin
      wr_pd = 8'(8'h70 + i);
      tick;
    end
    wr_pvld = 0;
    rstn = 0;
    #1;
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_pvld", int'(rd_pvld), 0);
    chk("t6_rst_prdy", int'(wr_prdy), 0);
    tick;
    rstn = 1;
    tick;
    wr_pvld = 1; wr_pd = 8'h11;
    tick;
    wr_pvld = 0;
    tick;
    samp;
    chk("t6_rst_next_pvld", int'(rd_pvld), 1);
    chk("t6_rst_next_pd", int'(rd_pd), 8'h11);
    chk("t6_rst_next_count", int'(count), 1);
    tick;
    drain;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
